// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: frame-level state encoding and helpers that derive
// register widths from configuration values. Used by the transmitter today
// and intended for the receiver as well.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Frame-level states. PARITY is part of the shared encoding even when a
    // block is built without parity support.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Width of the bit counter; covers 5..9 data bits and 1..2 stop bits.
    localparam int unsigned BIT_CNT_W = 4;

    // Pointer width for a power-of-two FIFO of the given depth.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: one extra bit so "full" is representable.
    function automatic int unsigned count_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit-timer width for a timer that counts 0..divisor-1.
    function automatic int unsigned timer_bits(input int unsigned divisor);
        return (divisor > 1) ? $clog2(divisor) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
// Synchronous single-clock FIFO with asynchronous active-high reset.
// Reset flushes the FIFO by clearing pointers and count; storage is untouched.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   push       in   write request (ignored when full)
//   push_data  in   WIDTH  word to write
//   pop        in   read request (ignored when empty)
//   pop_data   out  WIDTH  word at the read pointer (valid when !empty)
//   count      out  entries stored
//   full       out  count == DEPTH
//   empty      out  count == 0
// ----------------------------------------------------------------------------
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic [count_bits(DEPTH)-1:0]  count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam int unsigned CW = count_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; a flush only needs the pointers and count
    // cleared, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Words pushed on a strobe/ready handshake are
// queued in a FIFO and serialised LSB-first on a registered TX line. The bit
// timer restarts at every START bit, so frames are aligned to the start edge
// and back-to-back frames follow each other with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   - a parity bit (even, or odd when PARITY_ODD=1) follows the data
//   undefined - no parity state or logic; PARITY_ODD has no effect
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   data         in   DATA_BITS  word to transmit
//   data_strobe  in   push request, one word per cycle
//   ready        out  FIFO not full; a strobe is accepted only while high
//   serial       out  TX line, idles high, registered
//   busy         out  a frame is being shifted out
//   fifo_count   out  words waiting, excluding the one being shifted
//   overflow     out  one-cycle pulse the cycle after a refused strobe
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR    = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          data_strobe,
    output logic                          ready,
    output logic                          serial,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned TW = timer_bits(DIVISOR);
    localparam logic [TW-1:0]        TIMER_LAST = TW'(DIVISOR - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST  = BIT_CNT_W'(STOP_BITS - 1);

    uart_state_t            state;
    logic [TW-1:0]          timer;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_end;
    logic                   frame_end;
    logic                   pop;

`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`else
    // Parity is compiled out, so the parity sense is deliberately unused.
    logic                   unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
`endif

    // ready comes from the registered count only, so a push into a full FIFO
    // is refused even when a pop happens in the same cycle.
    assign ready     = !fifo_full;
    assign bit_end   = (timer == TIMER_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
    // Pop from IDLE, or on the last stop cycle so the next START follows
    // immediately.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_strobe),
        .push_data (data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The line level is registered together with the state: each transition
    // loads the level of the bit being entered, so serial has no decode glitch
    // and reset forces it high without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            serial     <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            overflow <= data_strobe && !ready;

            if (pop) begin
                state  <= ST_START;
                timer  <= '0;
                shift  <= fifo_data;
                serial <= 1'b0;
                busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                // Computed from the whole word now, before shifting consumes it.
                parity_bit <= (^fifo_data) ^ 1'(PARITY_ODD);
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        serial <= 1'b1;
                        busy   <= 1'b0;
                    end

                    ST_START: begin
                        if (bit_end) begin
                            timer   <= '0;
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                            serial  <= shift[0];
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    ST_DATA: begin
                        if (bit_end) begin
                            timer <= '0;
                            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state  <= ST_PARITY;
                                serial <= parity_bit;
`else
                                state   <= ST_STOP;
                                bit_cnt <= '0;
                                serial  <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                                shift   <= shift >> 1;
                                // shift[1] is the next bit once shift moves.
                                serial  <= shift[1];
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_end) begin
                            timer   <= '0;
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                            serial  <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
`endif

                    ST_STOP: begin
                        if (bit_end) begin
                            timer <= '0;
                            if (bit_cnt == STOP_LAST) begin
                                // FIFO empty here, otherwise pop took over.
                                state  <= ST_IDLE;
                                busy   <= 1'b0;
                                serial <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    default: begin
                        state  <= ST_IDLE;
                        timer  <= '0;
                        serial <= 1'b1;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Two transmitter instances: "a" is 8N1 with a 16-deep FIFO, "b" is 7 data
// bits, 2 stop bits, odd parity sense, 4-deep FIFO. A frame-position model
// (queue of waiting words + cycle offset into the current frame) predicts every
// output on every cycle; directed sections add hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F_A = 16 * (1 + 8 + P + 1);
    localparam int F_B = 16 * (1 + 7 + P + 2);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_data;
    logic       a_stb, a_ready, a_serial, a_busy, a_ovf;
    logic [4:0] a_count;
    logic [6:0] b_data;
    logic       b_stb, b_ready, b_serial, b_busy, b_ovf;
    logic [2:0] b_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DIVISOR(16), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .reset(reset), .data(a_data), .data_strobe(a_stb),
        .ready(a_ready), .serial(a_serial), .busy(a_busy),
        .fifo_count(a_count), .overflow(a_ovf)
    );

    uart_tx_fifo #(
        .DIVISOR(16), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) dut_b (
        .clk(clk), .reset(reset), .data(b_data), .data_strobe(b_stb),
        .ready(b_ready), .serial(b_serial), .busy(b_busy),
        .fifo_count(b_count), .overflow(b_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int tc = 0;
    int a_falls = 0;
    logic a_prev = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_div[2]   = '{16, 16};
    int m_dbits[2] = '{8, 7};
    int m_sbits[2] = '{1, 2};
    int m_depth[2] = '{16, 4};
    int m_podd[2]  = '{0, 1};
    int mq[2][32];
    int m_head[2], m_size[2], m_pos[2], m_cur[2];
    bit m_ovf[2];

    task automatic model_reset(input int id);
        m_head[id] = 0;
        m_size[id] = 0;
        m_pos[id]  = -1;
        m_cur[id]  = 0;
        m_ovf[id]  = 1'b0;
    endtask

    task automatic model_step(input int id, input bit stb, input int word);
        int  flen;
        bit  full;
        flen = m_div[id] * (1 + m_dbits[id] + P + m_sbits[id]);
        full = (m_size[id] == m_depth[id]);
        m_ovf[id] = stb && full;
        if (m_pos[id] >= 0 && m_pos[id] < flen - 1) begin
            m_pos[id]++;
        end else if (m_size[id] > 0) begin
            m_cur[id]  = mq[id][m_head[id]];
            m_head[id] = (m_head[id] + 1) % 32;
            m_size[id]--;
            m_pos[id]  = 0;
        end else begin
            m_pos[id] = -1;
        end
        if (stb && !full) begin
            mq[id][(m_head[id] + m_size[id]) % 32] = word;
            m_size[id]++;
        end
    endtask

    function automatic logic exp_serial(input int id);
        int slot;
        int par;
        if (m_pos[id] < 0) return 1'b1;
        slot = m_pos[id] / m_div[id];
        if (slot == 0) return 1'b0;
        if (slot <= m_dbits[id]) return 1'((m_cur[id] >> (slot - 1)) & 1);
        if (P == 1 && slot == m_dbits[id] + 1) begin
            par = m_podd[id];
            for (int i = 0; i < m_dbits[id]; i++) par ^= (m_cur[id] >> i) & 1;
            return 1'(par);
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_pack(input int id);
        return {20'b0, exp_serial(id), 1'(m_pos[id] >= 0),
                1'(m_size[id] != m_depth[id]), m_ovf[id], 8'(m_size[id])};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, a_stb, int'(a_data));
            model_step(1, b_stb, int'(b_data));
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("a_cycle", {20'b0, a_serial, a_busy, a_ready, a_ovf, 3'b0, a_count}, exp_pack(0));
        check("b_cycle", {20'b0, b_serial, b_busy, b_ready, b_ovf, 5'b0, b_count}, exp_pack(1));
        if (a_prev === 1'b1 && a_serial === 1'b0) a_falls++;
        a_prev = a_serial;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        tc++;
    endtask

    task automatic goto(input int target);
        while (tc < target) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tc = 0;
    endtask

    bit b41[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int rate[3] = '{2, 60, 250};
    int f0;

    initial begin
        reset = 1'b0;
        a_stb = 1'b0; a_data = '0;
        b_stb = 1'b0; b_data = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_serial", 32'(a_serial), 32'd1);
        check("rst_ready",  32'(a_ready),  32'd1);
        check("rst_busy",   32'(a_busy),   32'd0);
        check("rst_count",  32'(a_count),  32'd0);
        check("rst_ovf",    32'(a_ovf),    32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single word 0x41.
        do_reset();
        a_stb = 1'b1; a_data = 8'h41;
        tick();
        a_stb = 1'b0;
        check("t1_count_c1",  32'(a_count),  32'd1);
        check("t1_serial_c1", 32'(a_serial), 32'd1);
        tick();
        check("t1_start_c2", 32'(a_serial), 32'd0);
        check("t1_busy_c2",  32'(a_busy),   32'd1);
        check("t1_count_c2", 32'(a_count),  32'd0);
        for (int k = 0; k < 8; k++) begin
            goto(26 + 16 * k);
            check($sformatf("t1_bit%0d", k), 32'(a_serial), 32'(b41[k]));
        end
`ifdef UART_TX_PARITY_EN
        goto(154);
        check("t1_parity", 32'(a_serial), 32'd0);
`endif
        goto(26 + 16 * (8 + P));
        check("t1_stop", 32'(a_serial), 32'd1);
        goto(F_A + 1);
        check("t1_busy_last", 32'(a_busy), 32'd1);
        tick();
        check("t1_busy_fall", 32'(a_busy),   32'd0);
        check("t1_idle_line", 32'(a_serial), 32'd1);

        // Back-to-back 0x0D, 0x0A.
        do_reset();
        a_stb = 1'b1; a_data = 8'h0D;
        tick();
        a_data = 8'h0A;
        tick();
        a_stb = 1'b0;
        check("t2_count_c2", 32'(a_count), 32'd1);
        goto(F_A - 15);
`ifdef UART_TX_PARITY_EN
        check("t2_last_pre_stop", 32'(a_serial), 32'd1);
`else
        check("t2_last_pre_stop", 32'(a_serial), 32'd0);
`endif
        tick();
        check("t2_stop_first", 32'(a_serial), 32'd1);
        goto(F_A + 1);
        check("t2_stop_last", 32'(a_serial), 32'd1);
        tick();
        check("t2_second_start", 32'(a_serial), 32'd0);
        check("t2_busy_between", 32'(a_busy),   32'd1);
        goto(F_A + 2 + 16 + 16 + 8);
        check("t2_second_bit1", 32'(a_serial), 32'd1);

        // Overflow: 18 strobes into a 16-deep FIFO.
        do_reset();
        f0 = a_falls;
        for (int i = 0; i < 18; i++) begin
            a_stb = 1'b1; a_data = 8'hFF;
            if (i == 16) check("t3_ready_16", 32'(a_ready), 32'd1);
            if (i == 17) begin
                check("t3_ready_17", 32'(a_ready), 32'd0);
                check("t3_count_17", 32'(a_count), 32'd16);
            end
            tick();
        end
        a_stb = 1'b0;
        check("t3_ovf_pulse", 32'(a_ovf),   32'd1);
        check("t3_count_18",  32'(a_count), 32'd16);
        tick();
        check("t3_ovf_clear", 32'(a_ovf), 32'd0);
        goto(2 + 17 * F_A + 16);
        check("t3_frames", 32'(a_falls - f0), 32'(17 * (1 + P)));
        check("t3_done_busy", 32'(a_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity on word 0x55: even sense on a, odd sense on b.
        do_reset();
        a_stb = 1'b1; a_data = 8'h55;
        b_stb = 1'b1; b_data = 7'h55;
        tick();
        a_stb = 1'b0; b_stb = 1'b0;
        goto(138);
        check("t4_parity_odd", 32'(b_serial), 32'd1);
        goto(154);
        check("t4_parity_even", 32'(a_serial), 32'd0);
`endif

        // Two stop bits on b, two 0x00 words queued.
        do_reset();
        b_stb = 1'b1; b_data = 7'h00;
        tick();
        tick();
        b_stb = 1'b0;
`ifdef UART_TX_PARITY_EN
        goto(2 + F_B - 49);
        check("t5_last_data", 32'(b_serial), 32'd0);
        goto(2 + F_B - 33);
        check("t5_parity", 32'(b_serial), 32'd1);
`else
        goto(2 + F_B - 33);
        check("t5_last_data", 32'(b_serial), 32'd0);
`endif
        tick();
        check("t5_stop_first", 32'(b_serial), 32'd1);
        goto(2 + F_B - 1);
        check("t5_stop_last", 32'(b_serial), 32'd1);
        tick();
        check("t5_next_start", 32'(b_serial), 32'd0);

        // Async reset mid-frame with 3 words queued.
        do_reset();
        a_stb = 1'b1;
        a_data = 8'hFF; tick();
        a_data = 8'h11; tick();
        a_data = 8'h22; tick();
        a_data = 8'h33; tick();
        a_stb = 1'b0;
        goto(60);
        check("t6_pre_busy",  32'(a_busy),  32'd1);
        check("t6_pre_count", 32'(a_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("t6_async_serial", 32'(a_serial), 32'd1);
        check("t6_async_count",  32'(a_count),  32'd0);
        check("t6_async_busy",   32'(a_busy),   32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tc = 0;
        a_stb = 1'b1; a_data = 8'h00;
        tick();
        a_stb = 1'b0;
        tick();
        check("t6_clean_start", 32'(a_serial), 32'd0);
        goto(26 + 16 * 4);
        check("t6_clean_bit4", 32'(a_serial), 32'd0);
        goto(26 + 16 * (8 + P));
        check("t6_clean_stop", 32'(a_serial), 32'd1);
        goto(F_A + 2);
        check("t6_clean_end", 32'(a_busy), 32'd0);

        // Randomised traffic: overload, moderate and sparse phases.
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                a_stb  = ($urandom_range(0, rate[ph] - 1) == 0);
                a_data = 8'($urandom);
                b_stb  = ($urandom_range(0, rate[ph] - 1) == 0);
                b_data = 7'($urandom);
                tick();
            end
        end
        a_stb = 1'b0; b_stb = 1'b0;
        goto(tc + 17 * F_A + 50);
        check("t7_drain_a", 32'({a_busy, a_count}), 32'd0);
        check("t7_drain_b", 32'({b_busy, b_count}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
